// File: rtl/cnu_ib_pkg.sv
// ----------------------------------------------------------------------------
// cnu_ib_pkg
// Shared definitions for the check-node information-bottleneck LUT:
//   - default geometry (entry width, address width, depth, read channels)
//   - load FSM state encoding
//   - active_bank codes reported to the outside world
// ----------------------------------------------------------------------------
package cnu_ib_pkg;

    localparam int DEF_QUAN_SIZE = 4;
    localparam int DEF_IB_ADDR   = 8;
    localparam int DEF_RAM_DEPTH = 256;
    localparam int DEF_RD_CH     = 4;

    // Load FSM: idle, streaming the shadow bank, one-cycle completion
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } ib_state_e;

    // Which table is currently serving reads
    localparam logic [1:0] BANK_ID = 2'b00;
    localparam logic [1:0] BANK_0  = 2'b01;
    localparam logic [1:0] BANK_1  = 2'b10;

endpackage

// File: rtl/cnu_ib_lut_bank.sv
// ----------------------------------------------------------------------------
// cnu_ib_lut_bank
// One LUT bank: a single synchronous write port and RD_CH asynchronous read
// ports. Contents are never reset; the top only exposes a bank once it has
// been completely written.
// Ports:
//   clk      write clock (rising edge)
//   wr_en    write strobe
//   wr_addr  write address
//   wr_data  write data
//   rd_addr  RD_CH packed read addresses, channel c at [c*IB_ADDR +: IB_ADDR]
//   rd_data  RD_CH packed read data, channel c at [c*QUAN_SIZE +: QUAN_SIZE]
// ----------------------------------------------------------------------------
module cnu_ib_lut_bank
    import cnu_ib_pkg::*;
#(
    parameter int QUAN_SIZE = DEF_QUAN_SIZE,
    parameter int IB_ADDR   = DEF_IB_ADDR,
    parameter int RAM_DEPTH = DEF_RAM_DEPTH,
    parameter int RD_CH     = DEF_RD_CH
) (
    input  logic                       clk,
    input  logic                       wr_en,
    input  logic [IB_ADDR-1:0]         wr_addr,
    input  logic [QUAN_SIZE-1:0]       wr_data,
    input  logic [RD_CH*IB_ADDR-1:0]   rd_addr,
    output logic [RD_CH*QUAN_SIZE-1:0] rd_data
);

    logic [QUAN_SIZE-1:0] mem [RAM_DEPTH];

    // Single write port, used only by the shadow-bank loader
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Combinational read ports; the top registers them
    for (genvar c = 0; c < RD_CH; c++) begin : g_rd
        assign rd_data[c*QUAN_SIZE +: QUAN_SIZE] = mem[rd_addr[c*IB_ADDR +: IB_ADDR]];
    end

endmodule

// File: rtl/cnu_ib_lut_bank_ram.sv
// ----------------------------------------------------------------------------
// cnu_ib_lut_bank_ram
// Multi-channel reconfigurable IB lookup table for the CNU. Reads are served
// from the active table (identity, bank0 or bank1) with a fixed one-cycle
// latency and are never stalled. The inactive (shadow) bank is streamed in via
// a valid/ready interface and swapped in atomically once complete.
// Ports:
//   sys_clk      clock, rising edge
//   rst          synchronous active-high reset
//   rd_en        per-channel read strobe
//   rd_addr      packed read addresses
//   rd_data      packed registered read data (holds when rd_en is low)
//   rd_valid     per-channel data valid
//   load_start   begin loading the shadow bank (IDLE only)
//   load_valid   load_data is valid
//   load_data    next LUT entry, ascending address order
//   load_ready   loader accepts load_data
//   load_done    one-cycle pulse when the shadow bank is complete
//   swap_req     make the complete shadow bank active
//   active_bank  00 identity, 01 bank0, 10 bank1
//   busy         high while loading
// ----------------------------------------------------------------------------
module cnu_ib_lut_bank_ram
    import cnu_ib_pkg::*;
#(
    parameter int QUAN_SIZE = DEF_QUAN_SIZE,
    parameter int IB_ADDR   = DEF_IB_ADDR,
    parameter int RAM_DEPTH = DEF_RAM_DEPTH,
    parameter int RD_CH     = DEF_RD_CH
) (
    input  logic                       sys_clk,
    input  logic                       rst,
    input  logic [RD_CH-1:0]           rd_en,
    input  logic [RD_CH*IB_ADDR-1:0]   rd_addr,
    output logic [RD_CH*QUAN_SIZE-1:0] rd_data,
    output logic [RD_CH-1:0]           rd_valid,
    input  logic                       load_start,
    input  logic                       load_valid,
    input  logic [QUAN_SIZE-1:0]       load_data,
    output logic                       load_ready,
    output logic                       load_done,
    input  logic                       swap_req,
    output logic [1:0]                 active_bank,
    output logic                       busy
);

    localparam logic [IB_ADDR:0] LAST_IDX = (IB_ADDR+1)'(RAM_DEPTH - 1);

    ib_state_e state;
    ib_state_e state_next;

    logic [IB_ADDR:0] load_cnt;
    logic             shadow_full;
    logic             shadow_sel;
    logic             swap_fire;
    logic             start_fire;
    logic             write_fire;
    logic             last_write;

    logic [RD_CH*QUAN_SIZE-1:0] bank0_rd;
    logic [RD_CH*QUAN_SIZE-1:0] bank1_rd;
    logic [QUAN_SIZE-1:0]       rd_next [RD_CH];

    // The shadow is whichever bank is not serving reads; bank1 only when
    // bank0 is active.
    assign shadow_sel = (active_bank == BANK_0);

    // A swap has priority over a simultaneous load_start and drops it
    assign swap_fire  = (state == ST_IDLE) && swap_req && shadow_full;
    assign start_fire = (state == ST_IDLE) && load_start && !swap_fire;
    assign write_fire = load_valid && load_ready;
    assign last_write = write_fire && (load_cnt == LAST_IDX);

    // FSM state register
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start_fire) state_next = ST_LOAD;
            ST_LOAD: if (last_write) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM outputs, all decoded directly from the state
    always_comb begin
        load_ready = 1'b0;
        load_done  = 1'b0;
        busy       = 1'b0;
        case (state)
            ST_LOAD: begin
                load_ready = 1'b1;
                busy       = 1'b1;
            end
            ST_DONE: load_done = 1'b1;
            default: ;
        endcase
    end

    // Load counter, shadow-complete flag and active bank selection.
    // shadow_full is set on the final write so it is already high in DONE.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            load_cnt    <= '0;
            shadow_full <= 1'b0;
            active_bank <= BANK_ID;
        end else begin
            if (start_fire) begin
                load_cnt    <= '0;
                shadow_full <= 1'b0;
            end else if (write_fire) begin
                load_cnt <= load_cnt + 1'b1;
            end
            if (last_write) begin
                shadow_full <= 1'b1;
            end
            if (swap_fire) begin
                active_bank <= shadow_sel ? BANK_1 : BANK_0;
                shadow_full <= 1'b0;
            end
        end
    end

    cnu_ib_lut_bank #(
        .QUAN_SIZE (QUAN_SIZE),
        .IB_ADDR   (IB_ADDR),
        .RAM_DEPTH (RAM_DEPTH),
        .RD_CH     (RD_CH)
    ) u_bank0 (
        .clk     (sys_clk),
        .wr_en   (write_fire && !shadow_sel),
        .wr_addr (load_cnt[IB_ADDR-1:0]),
        .wr_data (load_data),
        .rd_addr (rd_addr),
        .rd_data (bank0_rd)
    );

    cnu_ib_lut_bank #(
        .QUAN_SIZE (QUAN_SIZE),
        .IB_ADDR   (IB_ADDR),
        .RAM_DEPTH (RAM_DEPTH),
        .RD_CH     (RD_CH)
    ) u_bank1 (
        .clk     (sys_clk),
        .wr_en   (write_fire && shadow_sel),
        .wr_addr (load_cnt[IB_ADDR-1:0]),
        .wr_data (load_data),
        .rd_addr (rd_addr),
        .rd_data (bank1_rd)
    );

    // Per-channel source select; identity returns the low address bits
    always_comb begin
        for (int c = 0; c < RD_CH; c++) begin
            rd_next[c] = rd_addr[c*IB_ADDR +: QUAN_SIZE];
            case (active_bank)
                BANK_0:  rd_next[c] = bank0_rd[c*QUAN_SIZE +: QUAN_SIZE];
                BANK_1:  rd_next[c] = bank1_rd[c*QUAN_SIZE +: QUAN_SIZE];
                default: ;
            endcase
        end
    end

    // Read output registers: one-cycle latency, data holds when not enabled.
    // Sampling active_bank before it updates makes swap-cycle reads see the
    // old table.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= '0;
        end else begin
            rd_valid <= rd_en;
            for (int c = 0; c < RD_CH; c++) begin
                if (rd_en[c]) begin
                    rd_data[c*QUAN_SIZE +: QUAN_SIZE] <= rd_next[c];
                end
            end
        end
    end

endmodule
